// File: rtl/adder_response_checker.sv
// Self-checking response end for adder benches: queues golden {cout,sum} per operand set
// and compares adder responses in order. Optional build macro: ADDER_CHECK_CAPTURE_EN.
module adder_response_checker #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             stim_valid,
  input  logic [WIDTH-1:0] stim_x,
  input  logic [WIDTH-1:0] stim_y,
  input  logic             stim_cin,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp_sum,
  input  logic             resp_cout,
  output logic             stim_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_pulse,
  output logic             proto_err,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH:0]   first_exp,
  output logic [WIDTH:0]   first_act
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = WIDTH + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  function automatic logic [EW-1:0] golden(input logic [WIDTH-1:0] x,
                                           input logic [WIDTH-1:0] y,
                                           input logic             c);
    return {1'b0, x} + {1'b0, y} + EW'(c);
  endfunction

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [1:0]       state, stateNxt;
  logic [EW-1:0]    mem [DEPTH];
  logic [AW:0]      wrPtr, rdPtr;
  logic             full, empty, checking, pop, push;
  logic             stimDrop, respOrphan, mismatch, startRun;
  logic [EW-1:0]    expHead, actResp;
  logic [CNT_W-1:0] passCnt, errCnt, passCntNxt, errCntNxt;
  logic             protoErr, protoNxt;

  assign empty      = (wrPtr == rdPtr);
  assign full       = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign checking   = (state == RUN) || (state == DRAIN);
  assign pop        = checking && resp_valid && !empty;
  // A same-cycle pop frees a slot, so a full FIFO can still take stimulus.
  assign stim_ready = !full || pop;
  assign push       = (state == RUN) && stim_valid && stim_ready;
  assign stimDrop   = (state == RUN) && stim_valid && !stim_ready;
  assign respOrphan = checking && resp_valid && empty;
  assign expHead    = mem[rdPtr[AW-1:0]];
  assign actResp    = {resp_cout, resp_sum};
  assign mismatch   = pop && (expHead != actResp);
  assign startRun   = start && ((state == IDLE) || (state == DONE));

  always_comb begin
    stateNxt   = state;
    passCntNxt = passCnt;
    errCntNxt  = errCnt;
    protoNxt   = protoErr;
    case (state)
      IDLE:    if (start) stateNxt = RUN;
      RUN:     if (stop)  stateNxt = DRAIN;
      DRAIN:   if (empty) stateNxt = DONE;
      DONE:    if (start) stateNxt = RUN;
      default: stateNxt = IDLE;
    endcase
    if (startRun) begin
      passCntNxt = '0;
      errCntNxt  = '0;
      protoNxt   = 1'b0;
    end else begin
      if (pop && !mismatch) passCntNxt = satInc(passCnt);
      if (mismatch)         errCntNxt  = satInc(errCnt);
      if (stimDrop || respOrphan) protoNxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wrPtr     <= '0;
      rdPtr     <= '0;
      passCnt   <= '0;
      errCnt    <= '0;
      protoErr  <= 1'b0;
      err_pulse <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      state     <= stateNxt;
      passCnt   <= passCntNxt;
      errCnt    <= errCntNxt;
      protoErr  <= protoNxt;
      err_pulse <= mismatch;
      done      <= (stateNxt == DONE);
      pass      <= (stateNxt == DONE) && (errCntNxt == '0) && !protoNxt;
      if (startRun) begin
        wrPtr <= '0;
        rdPtr <= '0;
      end else begin
        if (push) wrPtr <= wrPtr + (AW+1)'(1);
        if (pop)  rdPtr <= rdPtr + (AW+1)'(1);
      end
    end
  end

  // Expected-result storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr[AW-1:0]] <= golden(stim_x, stim_y, stim_cin);
  end

  assign busy       = checking;
  assign proto_err  = protoErr;
  assign pass_count = passCnt;
  assign err_count  = errCnt;

`ifdef ADDER_CHECK_CAPTURE_EN
  logic          captured;
  logic [EW-1:0] firstExp, firstAct;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      captured <= 1'b0;
      firstExp <= '0;
      firstAct <= '0;
    end else if (startRun) begin
      captured <= 1'b0;
      firstExp <= '0;
      firstAct <= '0;
    end else if (mismatch && !captured) begin
      captured <= 1'b1;
      firstExp <= expHead;
      firstAct <= actResp;
    end
  end

  assign first_exp = firstExp;
  assign first_act = firstAct;
`else
  assign first_exp = '0;
  assign first_act = '0;
`endif

endmodule
